// File: rtl/ncl_phase_sequencer_if.sv
// Handshake and dual-rail bus bundle for ncl_phase_sequencer.
// The sequencer connects through the slave modport; the environment (source, datapath, sink) uses master.
interface ncl_phase_sequencer_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               din_ready;
  logic [2*WIDTH-1:0] rail_out;
  logic [2*WIDTH-1:0] rail_in;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               busy;
  logic               err_timeout;
  logic [CNT_W-1:0]   last_latency;

  modport master (
    output din, din_valid, rail_in, dout_ready,
    input  din_ready, rail_out, dout, dout_valid, busy, err_timeout, last_latency
  );

  modport slave (
    input  din, din_valid, rail_in, dout_ready,
    output din_ready, rail_out, dout, dout_valid, busy, err_timeout, last_latency
  );
endinterface

// File: rtl/ncl_phase_sequencer.sv
// Clocked NULL/DATA wavefront sequencer for a dual-rail NCL datapath.
//   state      | meaning
//   IDLE       | rails at low NULL, waiting for an operand (or loop restart)
//   HNULL_WAIT | driving all-ones, waiting for returned high NULL
//   LNULL_WAIT | driving all-zeros, waiting for returned low NULL
//   DATA_WAIT  | driving encoded operand, waiting for complete DATA
//   OUT_HOLD   | result presented on dout until consumed
module ncl_phase_sequencer #(
  parameter int WIDTH         = 24,
  parameter int NULL_MODE     = 0,
  parameter int LOOP          = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  ncl_phase_sequencer_if.slave  bus
);
  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HNULL_WAIT, LNULL_WAIT, DATA_WAIT, OUT_HOLD} state_t;
  typedef enum logic [1:0] {CLS_MIXED, CLS_DATA, CLS_HNULL, CLS_LNULL} cls_t;

  localparam state_t          FIRST_WAIT = (NULL_MODE == 1) ? LNULL_WAIT : HNULL_WAIT;
  localparam logic [RW-1:0]   FIRST_RAIL = (NULL_MODE == 1) ? '0 : '1;

  logic [RW-1:0]    sync_q [SYNC_STAGES];
  logic [RW-1:0]    rail_s;
  cls_t             cls_now, cls_q;
  logic [SW-1:0]    stable_cnt;
  logic             all_diff, stable, det_cur, in_wait, timed_out;
  logic [RW-1:0]    enc_op;
  logic [WIDTH-1:0] dec;

  state_t           state;
  logic [RW-1:0]    rail_q;
  logic             din_ready_q, dout_valid_q, busy_q, err_q, loop_valid;
  logic [WIDTH-1:0] op_q, dout_q;
  logic [CNT_W-1:0] lat_cnt, last_lat_q;
  logic [TW-1:0]    wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.rail_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign rail_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    all_diff = 1'b1;
    cls_now  = CLS_MIXED;
    for (int i = 0; i < WIDTH; i++)
      if (rail_s[2*i+1] == rail_s[2*i]) all_diff = 1'b0;
    if (&rail_s)            cls_now = CLS_HNULL;
    else if (rail_s == '0)  cls_now = CLS_LNULL;
    else if (all_diff)      cls_now = CLS_DATA;
  end

  // Debounce: any change of class restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q      <= CLS_MIXED;
      stable_cnt <= '0;
    end else if (cls_now != cls_q) begin
      cls_q      <= cls_now;
      stable_cnt <= SW'(1);
    end else if (stable_cnt != SW'(STABLE_CYCLES)) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign stable = (stable_cnt == SW'(STABLE_CYCLES));

  // Only the class the current state is waiting for counts; stale wavefronts are ignored.
  always_comb begin
    det_cur = 1'b0;
    in_wait = 1'b1;
    case (state)
      HNULL_WAIT: det_cur = stable && (cls_q == CLS_HNULL);
      LNULL_WAIT: det_cur = stable && (cls_q == CLS_LNULL);
      DATA_WAIT:  det_cur = stable && (cls_q == CLS_DATA);
      default:    in_wait = 1'b0;
    endcase
    timed_out = in_wait && !det_cur && (wait_cnt == TW'(TIMEOUT - 1));
  end

  always_comb begin
    enc_op = '0;
    dec    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enc_op[2*i+1] = op_q[i];
      enc_op[2*i]   = ~op_q[i];
      dec[i]        = rail_s[2*i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rail_q       <= '0;
      din_ready_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      last_lat_q   <= '0;
      op_q         <= '0;
      loop_valid   <= 1'b0;
      wait_cnt     <= '0;
      lat_cnt      <= '0;
    end else if (timed_out) begin
      state       <= IDLE;
      rail_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b1;
      op_q        <= '0;
      loop_valid  <= 1'b0;
      din_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (LOOP != 0 && loop_valid) begin
            state    <= FIRST_WAIT;
            rail_q   <= FIRST_RAIL;
            busy_q   <= 1'b1;
            wait_cnt <= '0;
          end else if (bus.din_valid && din_ready_q) begin
            op_q        <= bus.din;
            loop_valid  <= (LOOP != 0);
            din_ready_q <= 1'b0;
            state       <= FIRST_WAIT;
            rail_q      <= FIRST_RAIL;
            busy_q      <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            din_ready_q <= 1'b1;
          end
        end
        HNULL_WAIT: begin
          if (det_cur) begin
            wait_cnt <= '0;
            if (NULL_MODE == 0) begin
              state  <= LNULL_WAIT;
              rail_q <= '0;
            end else begin
              state   <= DATA_WAIT;
              rail_q  <= enc_op;
              lat_cnt <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        LNULL_WAIT: begin
          if (det_cur) begin
            state    <= DATA_WAIT;
            rail_q   <= enc_op;
            lat_cnt  <= '0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DATA_WAIT: begin
          if (det_cur) begin
            state        <= OUT_HOLD;
            dout_q       <= dec;
            dout_valid_q <= 1'b1;
            last_lat_q   <= lat_cnt;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (lat_cnt != '1) lat_cnt <= lat_cnt + 1'b1;
          end
        end
        OUT_HOLD: begin
          if (dout_valid_q && bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            state        <= IDLE;
            rail_q       <= '0;
            busy_q       <= 1'b0;
            din_ready_q  <= (LOOP == 0);
            if (LOOP != 0) op_q <= dout_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rail_out     = rail_q;
  assign bus.din_ready    = din_ready_q;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.busy         = busy_q;
  assign bus.err_timeout  = err_q;
  assign bus.last_latency = last_lat_q;
endmodule

// File: tb/tb_ncl_phase_sequencer.sv
// Directed bench for ncl_phase_sequencer: three instances (two-phase NULL, low-NULL only, loop)
// each driving a 5-cycle dual-rail datapath model.
module tb_ncl_phase_sequencer;
  localparam logic [47:0] MIX = 48'h0000_0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic freeze0 = 1'b0;
  logic force0 = 1'b0;

  always #5 clk = ~clk;

  ncl_phase_sequencer_if #(.WIDTH(24), .CNT_W(16)) b0 ();
  ncl_phase_sequencer_if #(.WIDTH(24), .CNT_W(16)) b1 ();
  ncl_phase_sequencer_if #(.WIDTH(24), .CNT_W(16)) b2 ();

  ncl_phase_sequencer #(.WIDTH(24), .NULL_MODE(0), .LOOP(0), .SYNC_STAGES(2),
    .STABLE_CYCLES(2), .TIMEOUT(64), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  ncl_phase_sequencer #(.WIDTH(24), .NULL_MODE(1), .LOOP(0), .SYNC_STAGES(2),
    .STABLE_CYCLES(2), .TIMEOUT(1024), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  ncl_phase_sequencer #(.WIDTH(24), .NULL_MODE(0), .LOOP(1), .SYNC_STAGES(2),
    .STABLE_CYCLES(2), .TIMEOUT(1024), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  function automatic logic [47:0] enc(input logic [23:0] v);
    logic [47:0] r;
    for (int i = 0; i < 24; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic [47:0] inc_dr(input logic [47:0] r);
    logic ok;
    logic [23:0] x;
    ok = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (r[2*i+1] == r[2*i]) ok = 1'b0;
      x[i] = r[2*i+1];
    end
    return ok ? enc(x + 24'd1) : r;
  endfunction

  logic [47:0] p0 [5];
  logic [47:0] p1 [5];
  logic [47:0] p2 [5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        p0[k] <= '0; p1[k] <= '0; p2[k] <= '0;
      end
    end else begin
      p0[0] <= b0.rail_out;
      p1[0] <= b1.rail_out;
      p2[0] <= inc_dr(b2.rail_out);
      for (int k = 1; k < 5; k++) begin
        p0[k] <= p0[k-1]; p1[k] <= p1[k-1]; p2[k] <= p2[k-1];
      end
    end
  end

  assign b0.rail_in = freeze0 ? MIX : (force0 ? {p0[4][47:2], 2'b00} : p0[4]);
  assign b1.rail_in = p1[4];
  assign b2.rail_in = p2[4];

  task automatic send0(input logic [23:0] d);
    int n;
    n = 0;
    @(negedge clk);
    b0.din = d;
    b0.din_valid = 1'b1;
    while (b0.din_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b0.din_ready !== 1'b1) begin
      errors++; $display("FAIL send0_ready: din_ready=%b expected 1", b0.din_ready);
    end
    @(posedge clk); #1;
    b0.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (b0.rail_out !== 48'h0)   begin errors++; $display("FAIL rst_rail_out: got %h expected 0", b0.rail_out); end
    if (b0.din_ready !== 1'b0)   begin errors++; $display("FAIL rst_din_ready: got %b expected 0", b0.din_ready); end
    if (b0.dout !== 24'h0)       begin errors++; $display("FAIL rst_dout: got %h expected 0", b0.dout); end
    if (b0.dout_valid !== 1'b0)  begin errors++; $display("FAIL rst_dout_valid: got %b expected 0", b0.dout_valid); end
    if (b0.busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b expected 0", b0.busy); end
    if (b0.err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", b0.err_timeout); end
    if (b0.last_latency !== 16'h0) begin errors++; $display("FAIL rst_latency: got %0d expected 0", b0.last_latency); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (b0.din_ready !== 1'b1) begin errors++; $display("FAIL idle_din_ready0: got %b expected 1", b0.din_ready); end
    if (b2.din_ready !== 1'b1) begin errors++; $display("FAIL idle_din_ready2: got %b expected 1", b2.din_ready); end
  endtask

  task automatic test_null_mode0();
    logic [47:0] prev;
    logic [47:0] seq [4];
    int nchg;
    bit done;
    for (int k = 0; k < 4; k++) seq[k] = 48'h5;
    b0.dout_ready = 1'b0;
    send0(24'h00A5F3);
    prev = '0; nchg = 0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (b0.rail_out !== prev) begin
        if (nchg < 4) seq[nchg] = b0.rail_out;
        nchg++;
        prev = b0.rail_out;
      end
      if (b0.dout_valid === 1'b1) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks += 7;
    if (!done) begin errors++; $display("FAIL m0_done: dout_valid never rose, expected 1"); end
    if (nchg !== 3) begin errors++; $display("FAIL m0_phase_count: got %0d expected 3", nchg); end
    if (seq[0] !== {48{1'b1}}) begin errors++; $display("FAIL m0_hnull: got %h expected all ones", seq[0]); end
    if (seq[1] !== 48'h0) begin errors++; $display("FAIL m0_lnull: got %h expected 0", seq[1]); end
    if (seq[2] !== enc(24'h00A5F3)) begin errors++; $display("FAIL m0_data: got %h expected %h", seq[2], enc(24'h00A5F3)); end
    if (b0.dout !== 24'h00A5F3) begin errors++; $display("FAIL m0_dout: got %h expected 00a5f3", b0.dout); end
    if (b0.last_latency < 16'd8 || b0.last_latency > 16'd10) begin
      errors++; $display("FAIL m0_latency: got %0d expected 9 +/- 1", b0.last_latency);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (b0.dout_valid !== 1'b1) begin errors++; $display("FAIL m0_hold_valid: got %b expected 1", b0.dout_valid); end
    b0.dout_ready = 1'b1;
    @(posedge clk); #1;
    b0.dout_ready = 1'b0;
    checks += 3;
    if (b0.dout_valid !== 1'b0) begin errors++; $display("FAIL m0_consume_valid: got %b expected 0", b0.dout_valid); end
    if (b0.busy !== 1'b0) begin errors++; $display("FAIL m0_consume_busy: got %b expected 0", b0.busy); end
    if (b0.rail_out !== 48'h0) begin errors++; $display("FAIL m0_consume_rail: got %h expected 0", b0.rail_out); end
  endtask

  task automatic test_null_mode1();
    logic [47:0] prev, first;
    int nchg, n;
    bit done, saw_ones;
    b1.dout_ready = 1'b0;
    @(negedge clk);
    b1.din = 24'h000001; b1.din_valid = 1'b1;
    n = 0;
    while (b1.din_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b1.din_valid = 1'b0;
    prev = '0; first = 48'h5; nchg = 0; done = 1'b0; saw_ones = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (b1.rail_out === {48{1'b1}}) saw_ones = 1'b1;
      if (b1.rail_out !== prev) begin
        if (nchg == 0) first = b1.rail_out;
        nchg++;
        prev = b1.rail_out;
      end
      if (b1.dout_valid === 1'b1) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks += 5;
    if (!done) begin errors++; $display("FAIL m1_done: dout_valid never rose, expected 1"); end
    if (saw_ones) begin errors++; $display("FAIL m1_no_hnull: saw all-ones rail_out, expected none"); end
    if (nchg !== 1) begin errors++; $display("FAIL m1_phase_count: got %0d expected 1", nchg); end
    if (first !== enc(24'h000001)) begin errors++; $display("FAIL m1_data: got %h expected %h", first, enc(24'h000001)); end
    if (b1.dout !== 24'h000001) begin errors++; $display("FAIL m1_dout: got %h expected 000001", b1.dout); end
    b1.dout_ready = 1'b1;
    @(posedge clk); #1;
    b1.dout_ready = 1'b0;
  endtask

  task automatic test_loop();
    logic [23:0] vals [4];
    int got, bad_ready, n;
    b2.dout_ready = 1'b1;
    @(negedge clk);
    b2.din = 24'h0; b2.din_valid = 1'b1;
    n = 0;
    while (b2.din_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b2.din_valid = 1'b0;
    got = 0; bad_ready = 0;
    for (int k = 0; k < 4; k++) vals[k] = 24'hFFFFFF;
    for (int c = 0; c < 400 && got < 4; c++) begin
      if (b2.din_ready !== 1'b0) bad_ready++;
      if (b2.dout_valid === 1'b1) begin vals[got] = b2.dout; got++; end
      @(posedge clk); #1;
    end
    checks += 2;
    if (got !== 4) begin errors++; $display("FAIL loop_count: got %0d results expected 4", got); end
    if (bad_ready !== 0) begin errors++; $display("FAIL loop_din_ready: high %0d cycles expected 0", bad_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vals[k] !== 24'(k + 1)) begin
        errors++; $display("FAIL loop_dout%0d: got %h expected %h", k, vals[k], 24'(k + 1));
      end
    end
  endtask

  task automatic test_glitch_hold();
    logic [47:0] e;
    logic [23:0] held;
    int n, early, unstable, extra;
    e = enc(24'h5A5A5A);
    b0.dout_ready = 1'b0;
    send0(24'h5A5A5A);
    n = 0;
    while (b0.rail_out !== e && n < 60) begin @(posedge clk); #1; n++; end
    force0 = 1'b1;
    early = 0;
    repeat (10) begin @(posedge clk); #1; if (b0.dout_valid !== 1'b0) early++; end
    force0 = 1'b0;
    @(posedge clk); #1;
    force0 = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (b0.dout_valid !== 1'b0) early++; end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL glitch_early: dout_valid high %0d cycles expected 0", early); end
    force0 = 1'b0;
    n = 0;
    while (b0.dout_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (b0.dout_valid !== 1'b1) begin errors++; $display("FAIL glitch_done: dout_valid=%b expected 1", b0.dout_valid); end
    if (b0.dout !== 24'h5A5A5A) begin errors++; $display("FAIL glitch_dout: got %h expected 5a5a5a", b0.dout); end
    held = b0.dout;
    unstable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (b0.dout !== 24'h5A5A5A || b0.dout_valid !== 1'b1) unstable++;
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles expected 0 (held %h)", unstable, held); end
    b0.dout_ready = 1'b1;
    @(posedge clk); #1;
    b0.dout_ready = 1'b0;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (b0.dout_valid !== 1'b0 || b0.busy !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL no_second_result: %0d active cycles expected 0", extra); end
  endtask

  task automatic test_timeout();
    int pre, post, n;
    freeze0 = 1'b1;
    b0.dout_ready = 1'b0;
    send0(24'h123456);
    pre = 0;
    repeat (63) begin
      @(posedge clk); #1;
      if (b0.err_timeout !== 1'b0 || b0.busy !== 1'b1 || b0.dout_valid !== 1'b0) pre++;
    end
    checks++;
    if (pre !== 0) begin errors++; $display("FAIL to_early: %0d bad cycles before cycle 64 expected 0", pre); end
    @(posedge clk); #1;
    checks += 4;
    if (b0.err_timeout !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", b0.err_timeout); end
    if (b0.rail_out !== 48'h0) begin errors++; $display("FAIL to_rail: got %h expected 0", b0.rail_out); end
    if (b0.busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", b0.busy); end
    if (b0.dout_valid !== 1'b0) begin errors++; $display("FAIL to_valid: got %b expected 0", b0.dout_valid); end
    freeze0 = 1'b0;
    post = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b0.dout_valid !== 1'b0 || b0.err_timeout !== 1'b1) post++;
    end
    checks++;
    if (post !== 0) begin errors++; $display("FAIL to_after: %0d bad cycles expected 0", post); end
    send0(24'hABCDEF);
    n = 0;
    while (b0.dout_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (b0.dout !== 24'hABCDEF) begin errors++; $display("FAIL to_next_dout: got %h expected abcdef", b0.dout); end
    if (b0.err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", b0.err_timeout); end
    b0.dout_ready = 1'b1;
    @(posedge clk); #1;
    b0.dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    b0.dout_ready = 1'b0;
    send0(24'h3C3C3C);
    n = 0;
    while (b0.rail_out !== enc(24'h3C3C3C) && n < 60) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (b0.rail_out !== 48'h0) begin errors++; $display("FAIL rm_rail: got %h expected 0", b0.rail_out); end
    if (b0.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", b0.busy); end
    if (b0.dout_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", b0.dout_valid); end
    if (b0.err_timeout !== 1'b0) begin errors++; $display("FAIL rm_err: got %b expected 0", b0.err_timeout); end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    send0(24'h0F0F0F);
    n = 0;
    while (b0.dout_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (b0.dout_valid !== 1'b1) begin errors++; $display("FAIL rm_next_valid: got %b expected 1", b0.dout_valid); end
    if (b0.dout !== 24'h0F0F0F) begin errors++; $display("FAIL rm_next_dout: got %h expected 0f0f0f", b0.dout); end
    b0.dout_ready = 1'b1;
    @(posedge clk); #1;
    b0.dout_ready = 1'b0;
  endtask

  initial begin
    b0.din = '0; b0.din_valid = 1'b0; b0.dout_ready = 1'b0;
    b1.din = '0; b1.din_valid = 1'b0; b1.dout_ready = 1'b0;
    b2.din = '0; b2.din_valid = 1'b0; b2.dout_ready = 1'b0;
    test_reset();
    test_null_mode0();
    test_null_mode1();
    test_loop();
    test_glitch_hold();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ncl_phase_sequencer.md
Name: ncl_phase_sequencer

Overview:
- Clocked phase controller for a dual-rail NULL-convention combinational datapath, parametrised in width.
- Accepts binary operands over a valid/ready handshake and encodes them to dual-rail.
- Sequences NULL/DATA wavefronts into the datapath, detects completion on the returned rails and decodes results onto a valid/ready output.
- Adds over the previous generation: a selectable NULL mode, a feedback loop mode, debounced completion detection, a timeout watchdog and per-transaction latency measurement.

Parameters:
- WIDTH, 24, logical bits; each rail bus is 2*WIDTH.
- NULL_MODE, 0, 0 = high NULL then low NULL per transaction; 1 = low NULL only; 2 = high NULL only.
- LOOP, 0, 1 = after the first accepted operand, each result is fed back as the next operand without din handshake.
- SYNC_STAGES, 2, synchroniser flops on rail_in, minimum 2.
- STABLE_CYCLES, 2, consecutive identical classifications required to declare completion, minimum 1.
- TIMEOUT, 1024, maximum cycles spent in any wait state.
- CNT_W, 16, width of latency counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  WIDTH  operand
- din_valid  in  1  operand valid
- din_ready  out  1  operand accepted when din_valid & din_ready
- rail_out  out  2*WIDTH  dual-rail drive to datapath
- rail_in  in  2*WIDTH  dual-rail result from datapath (asynchronous)
- dout  out  WIDTH  decoded result
- dout_valid  out  1  result valid
- dout_ready  in  1  result consumed
- busy  out  1  FSM not in IDLE
- err_timeout  out  1  sticky; cleared only by reset
- last_latency  out  CNT_W  cycles from entering DATA_WAIT to completion for last result; saturates at all-ones

Behaviour:
- Encoding per logical bit i, pair {rail[2i+1], rail[2i]}:
  - DATA1 = 10, DATA0 = 01.
  - High NULL = 11, low NULL = 00.
  - Decode: dout[i] = rail_in[2i+1].
- Classification (after SYNC_STAGES flops), one of ALL_DATA / ALL_HNULL / ALL_LNULL / MIXED:
  - ALL_DATA: every pair differs.
  - ALL_HNULL: every rail 1.
  - ALL_LNULL: every rail 0.
  - MIXED: anything else.
- Debounce: a stable counter resets whenever the classification changes. A class is "detected" when it has been held STABLE_CYCLES cycles.
- Reset (async): state IDLE, rail_out all 0, din_ready 0, dout 0, dout_valid 0, busy 0, err_timeout 0, last_latency 0, loop operand register 0.
- FSM states: IDLE, HNULL_WAIT, LNULL_WAIT, DATA_WAIT, OUT_HOLD.
- IDLE:
  - rail_out = low NULL; din_ready = 1, or 0 when LOOP=1 and a loop operand is held.
  - On accept, latch operand. Go to HNULL_WAIT if NULL_MODE is 0 or 2, else LNULL_WAIT.
  - LOOP=1 with held operand: start automatically, no handshake.
- HNULL_WAIT: rail_out = all 1. On ALL_HNULL detected: go to LNULL_WAIT if NULL_MODE=0, else DATA_WAIT.
- LNULL_WAIT: rail_out = all 0. On ALL_LNULL detected: go to DATA_WAIT.
- DATA_WAIT:
  - rail_out = encoded operand.
  - Latency counter clears on entry and increments each cycle.
  - On ALL_DATA detected: register dout, set dout_valid = 1, capture the counter into last_latency, go to OUT_HOLD.
- OUT_HOLD:
  - rail_out holds DATA; dout and dout_valid are held stable.
  - When dout_valid & dout_ready: dout_valid = 0 next cycle.
  - LOOP=1: operand <= dout, return to IDLE, which auto-starts.
  - LOOP=0: return to IDLE.
- Simultaneous completion and dout_ready: dout_valid is asserted at least one cycle; no combinational ready-to-valid path.
- Timeout: a wait-cycle counter clears on each wait-state entry.
  - Reaching TIMEOUT in any wait state sets err_timeout, drives low NULL and returns to IDLE.
  - No dout_valid is generated; the loop operand is cleared.
- Detection must use only the class matching the current state. A stale ALL_DATA seen while in HNULL_WAIT is ignored.
- rail_out is registered only and changes only on state transitions; no glitches on rail_out.
- Reset asserted mid-transaction: immediate return to reset values, including rail_out = 00 on every pair.

Test Plan (bench datapath model: dual-rail identity, 5-cycle delay):
- NULL_MODE=0, WIDTH=24: din=24'h00A5F3 accepted -> rail_out goes all-1 then all-0 then DATA pairs; dout=24'h00A5F3, dout_valid=1; last_latency = 5+SYNC_STAGES+STABLE_CYCLES (9) ± 1.
- NULL_MODE=1: din=24'h000001 -> rail_out never all-1; goes 00 then DATA; dout=24'h000001.
- LOOP=1 with a dual-rail incrementer model: din=0 -> successive dout = 1, 2, 3, 4 with dout_ready held 1; din_ready stays 0 after the first accept.
- Datapath model frozen at MIXED, TIMEOUT=64 -> err_timeout=1 64 cycles after entering the wait state; rail_out returns to 0; no dout_valid; err_timeout persists until rst_n=0.
- Single-pair glitch shorter than STABLE_CYCLES during DATA_WAIT -> no early completion; dout_ready held 0 for 10 cycles -> dout stable, no second result.
- rst_n pulsed low in DATA_WAIT -> rail_out=0, busy=0, dout_valid=0 within the same cycle; next transaction completes normally.
